mac_tx_arbiter: RTL and testbench

MAC_TX_ARBITER -- requirements
Module: mac_tx_arbiter

---
 rtl/mac_tx_arb_pkg.sv | 14 +
 rtl/mac_tx_arbiter_rr.sv | 39 +++
 rtl/mac_tx_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mac_tx_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_tx_arb_pkg.sv
// Shared types and defaults for the MAC transmit arbiter.
package mac_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_FLUSH = 2'd3
    } arb_state_t;

    localparam int DEFAULT_NUM_PORTS = 2;
    localparam int DEFAULT_TIMEOUT   = 64;

endpackage

// File: rtl/mac_tx_arbiter_rr.sv
// Combinational round-robin picker: first requester above last_grant, wrapping to 0.
module rr_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS
) (
    input  logic [NUM_PORTS-1:0]         req,
    input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic                         any_req
);

    localparam int IW = $clog2(NUM_PORTS);

    logic [IW-1:0] low_idx;
    logic [IW-1:0] high_idx;
    logic          high_hit;

    // Descending scan so the lowest matching index in each half wins.
    always_comb begin
        low_idx  = '0;
        high_idx = '0;
        high_hit = 1'b0;
        for (int j = NUM_PORTS - 1; j >= 0; j--) begin
            if (req[IW'(j)]) begin
                if (IW'(j) > last_grant) begin
                    high_idx = IW'(j);
                    high_hit = 1'b1;
                end else begin
                    low_idx = IW'(j);
                end
            end
        end
    end

    assign grant_idx = high_hit ? high_idx : low_idx;
    assign any_req   = |req;

endmodule

// File: rtl/mac_tx_arbiter.sv
// Packet-granular round-robin mux of AXI-stream byte sources onto one MAC tx port,
// with stall timeout that emits an error terminator and discards the rest of the packet.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no owner; next requester after last_grant is picked
// ST_PASS  | granted port wired straight through to the MAC
// ST_ABORT | source stalled too long; emit 8'h00 with tlast and tuser
// ST_FLUSH | swallow the remaining source beats up to its tlast
module mac_tx_arbiter
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_PORTS = DEFAULT_NUM_PORTS,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_PORTS*8-1:0]       s_axis_tdata,
    input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
    input  logic [NUM_PORTS-1:0]         s_axis_tlast,
    input  logic [NUM_PORTS-1:0]         s_axis_tuser,
    output logic [NUM_PORTS-1:0]         s_axis_tready,
    output logic [7:0]                   m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser,
    input  logic                         m_axis_tready,
    output logic                         grant_valid,
    output logic [$clog2(NUM_PORTS)-1:0] grant_idx,
    output logic [15:0]                  abort_count
);

    localparam int          IW         = $clog2(NUM_PORTS);
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT - 1);

    arb_state_t    state;
    logic [IW-1:0] grant;
    logic          grant_active;
    logic [IW-1:0] last_grant;
    logic [15:0]   stall_cnt;

    logic [IW-1:0] rr_idx;
    logic          any_req;

    logic [7:0]    sel_data;
    logic          sel_valid;
    logic          sel_last;
    logic          sel_user;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr (
        .req        (s_axis_tvalid),
        .last_grant (last_grant),
        .grant_idx  (rr_idx),
        .any_req    (any_req)
    );

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_user  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant == IW'(i)) begin
                sel_data  = s_axis_tdata[8*i +: 8];
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_user  = s_axis_tuser[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            grant        <= '0;
            grant_active <= 1'b0;
            last_grant   <= IW'(NUM_PORTS - 1);
            stall_cnt    <= '0;
            abort_count  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (any_req) begin
                        state        <= ST_PASS;
                        grant        <= rr_idx;
                        grant_active <= 1'b1;
                    end
                end
                ST_PASS: begin
                    // A completing tlast transfer always beats the timeout.
                    if (sel_valid && m_axis_tready && sel_last) begin
                        state        <= ST_IDLE;
                        last_grant   <= grant;
                        grant        <= '0;
                        grant_active <= 1'b0;
                        stall_cnt    <= '0;
                    end else if (sel_valid) begin
                        stall_cnt <= '0;
                    end else if (stall_cnt == STALL_LAST) begin
                        state     <= ST_ABORT;
                        stall_cnt <= '0;
                        if (abort_count != 16'hFFFF) begin
                            abort_count <= abort_count + 16'd1;
                        end
                    end else begin
                        stall_cnt <= stall_cnt + 16'd1;
                    end
                end
                ST_ABORT: begin
                    if (m_axis_tready) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (sel_valid && sel_last) begin
                        state        <= ST_IDLE;
                        last_grant   <= grant;
                        grant        <= '0;
                        grant_active <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are forced quiet while rst is high, before the first reset edge lands.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
        if (!rst) begin
            case (state)
                ST_PASS: begin
                    m_axis_tdata         = sel_data;
                    m_axis_tvalid        = sel_valid;
                    m_axis_tlast         = sel_last;
                    m_axis_tuser         = sel_user;
                    s_axis_tready[grant] = m_axis_tready;
                end
                ST_ABORT: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tlast  = 1'b1;
                    m_axis_tuser  = 1'b1;
                end
                ST_FLUSH: begin
                    s_axis_tready[grant] = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign grant_valid = grant_active & ~rst;
    assign grant_idx   = rst ? '0 : grant;

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Bench for mac_tx_arbiter: scripted and random sources, a packet-level reference
// model compared every cycle, plus literal checks of the directed scenarios.
module tb_mac_tx_arbiter;

    localparam int NP = 2;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic [NP*8-1:0] s_axis_tdata;
    logic [NP-1:0]   s_axis_tvalid;
    logic [NP-1:0]   s_axis_tlast;
    logic [NP-1:0]   s_axis_tuser;
    logic [NP-1:0]   s_axis_tready;
    logic [7:0]      m_axis_tdata;
    logic            m_axis_tvalid;
    logic            m_axis_tlast;
    logic            m_axis_tuser;
    logic            m_axis_tready;
    logic            grant_valid;
    logic [0:0]      grant_idx;
    logic [15:0]     abort_count;

    mac_tx_arbiter #(
        .NUM_PORTS (NP),
        .TIMEOUT   (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .abort_count   (abort_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       idle;
        logic [7:0] data;
        logic       last;
        logic       user;
    } item_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
        logic       gidx;
    } beat_t;

    item_t q0[$];
    item_t q1[$];
    beat_t mac_log[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [NP-1:0] acc = '0;
    logic [NP-1:0] shown = '0;
    logic          flush_req = 1'b0;
    int            ready_mode = 0;

    // reference model: who owns the output and what it is doing with it
    int m_owner  = -1;
    int m_last   = NP - 1;
    int m_phase  = 0;     // 0 forwarding, 1 owes the error beat, 2 discarding
    int m_idle   = 0;
    int m_aborts = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int p);
        return (p == 0) ? q0.size() : q1.size();
    endfunction

    function automatic item_t qhead(input int p);
        return (p == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int p);
        if (p == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic push_item(input int p, input item_t it);
        if (p == 0) q0.push_back(it);
        else        q1.push_back(it);
    endtask

    task automatic push_beat(input int p, input logic [7:0] d, input logic l, input logic u);
        item_t it;
        it.idle = 1'b0; it.data = d; it.last = l; it.user = u;
        push_item(p, it);
    endtask

    task automatic push_idle(input int p, input int n);
        item_t it;
        it = '0;
        it.idle = 1'b1;
        for (int i = 0; i < n; i++) push_item(p, it);
    endtask

    task automatic push_pkt(input int p, input int len);
        for (int i = 0; i < len; i++)
            push_beat(p, 8'((p == 1 ? 128 : 0) + i), (i == len - 1), 1'b0);
    endtask

    // source driver: beats pop when accepted, idle slots pop after one cycle
    initial begin
        item_t it;
        s_axis_tdata  = '0;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (flush_req) begin
                q0.delete();
                q1.delete();
                shown = '0;
                flush_req = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                if (shown[p] && qsize(p) > 0) begin
                    it = qhead(p);
                    if (it.idle || acc[p]) qpop(p);
                end
                if (qsize(p) > 0) begin
                    it = qhead(p);
                    shown[p] = 1'b1;
                    s_axis_tvalid[p] = ~it.idle;
                    s_axis_tdata[8*p +: 8] = it.data;
                    s_axis_tlast[p] = it.last;
                    s_axis_tuser[p] = it.user;
                end else begin
                    shown[p] = 1'b0;
                    s_axis_tvalid[p] = 1'b0;
                    s_axis_tlast[p] = 1'b0;
                    s_axis_tuser[p] = 1'b0;
                end
            end
            case (ready_mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = ~m_axis_tready;
                default: m_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // compare process: predict outputs from model + current inputs, then advance
    always @(negedge clk) begin
        logic       e_valid, e_last, e_user;
        logic [7:0] e_data;
        logic [1:0] e_ready;
        int         c;
        e_valid = 1'b0; e_last = 1'b0; e_user = 1'b0; e_data = '0; e_ready = '0;
        if (rst) begin
            check("rst_m_tvalid", 32'(m_axis_tvalid), 0);
            check("rst_s_tready", 32'(s_axis_tready), 0);
            check("rst_grant_valid", 32'(grant_valid), 0);
            check("rst_grant_idx", 32'(grant_idx), 0);
            acc = '0;
            m_owner = -1; m_last = NP - 1; m_phase = 0; m_idle = 0; m_aborts = 0;
        end else begin
            if (m_owner >= 0) begin
                if (m_phase == 0) begin
                    e_valid = s_axis_tvalid[m_owner];
                    e_last  = s_axis_tlast[m_owner];
                    e_user  = s_axis_tuser[m_owner];
                    e_data  = s_axis_tdata[8*m_owner +: 8];
                    e_ready[m_owner] = m_axis_tready;
                end else if (m_phase == 1) begin
                    e_valid = 1'b1; e_last = 1'b1; e_user = 1'b1; e_data = 8'h00;
                end else begin
                    e_ready[m_owner] = 1'b1;
                end
            end
            check("m_tvalid", 32'(m_axis_tvalid), 32'(e_valid));
            check("s_tready", 32'(s_axis_tready), 32'(e_ready));
            check("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
            check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 0 : m_owner);
            check("abort_count", 32'(abort_count), m_aborts);
            if (e_valid) begin
                check("m_tdata", 32'(m_axis_tdata), 32'(e_data));
                check("m_tlast", 32'(m_axis_tlast), 32'(e_last));
                check("m_tuser", 32'(m_axis_tuser), 32'(e_user));
            end
            if (m_axis_tvalid && m_axis_tready)
                mac_log.push_back({m_axis_tdata, m_axis_tlast, m_axis_tuser, grant_idx});
            acc = s_axis_tvalid & s_axis_tready;

            if (m_owner < 0) begin
                for (int k = 1; k <= NP; k++) begin
                    c = (m_last + k) % NP;
                    if (m_owner < 0 && s_axis_tvalid[c]) begin
                        m_owner = c; m_phase = 0; m_idle = 0;
                    end
                end
            end else if (m_phase == 1) begin
                if (m_axis_tready) m_phase = 2;
            end else if (m_phase == 2) begin
                if (s_axis_tvalid[m_owner] && s_axis_tlast[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end
            end else begin
                if (s_axis_tvalid[m_owner] && m_axis_tready && s_axis_tlast[m_owner]) begin
                    m_last = m_owner; m_owner = -1;
                end else if (s_axis_tvalid[m_owner]) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_phase = 1; m_idle = 0;
                        if (m_aborts < 65535) m_aborts++;
                    end
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(q0.size() == 0 && q1.size() == 0 && m_owner < 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (n >= budget) check("drain_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        flush_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        int n;
        int len;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_grant_valid", 32'(grant_valid), 0);
        check("reset_m_tvalid", 32'(m_axis_tvalid), 0);
        check("reset_s_tready", 32'(s_axis_tready), 0);
        check("reset_grant_idx", 32'(grant_idx), 0);
        check("reset_abort_count", 32'(abort_count), 0);
        @(posedge clk);
        #1;

        // single port, 60 bytes
        mac_log.delete();
        push_pkt(0, 60);
        wait_idle(2000);
        check("t1_beats", mac_log.size(), 60);
        bad = 0;
        foreach (mac_log[i])
            if (mac_log[i] != {8'(i), (i == 59), 1'b0, 1'b0}) bad++;
        check("t1_content", bad, 0);
        check("t1_aborts", 32'(abort_count), 0);

        // fairness: back-to-back 64-byte packets on both ports
        do_reset();
        mac_log.delete();
        for (int k = 0; k < 3; k++) begin
            push_pkt(0, 64);
            push_pkt(1, 64);
        end
        wait_idle(3000);
        check("t2_beats", mac_log.size(), 384);
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_grant%0d", k), 32'(mac_log[64*k].gidx), k % 2);
            for (int j = 0; j < 64; j++)
                if (mac_log[64*k+j] != {8'((k % 2) * 128 + j), (j == 63), 1'b0, 1'(k % 2)})
                    bad++;
        end
        check("t2_no_interleave", bad, 0);

        // backpressure toggling during a 100-byte packet
        mac_log.delete();
        ready_mode = 1;
        push_pkt(0, 100);
        wait_idle(2000);
        ready_mode = 0;
        check("t3_beats", mac_log.size(), 100);
        bad = 0;
        foreach (mac_log[i])
            if (mac_log[i] != {8'(i), (i == 99), 1'b0, 1'b0}) bad++;
        check("t3_content", bad, 0);
        check("t3_aborts", 32'(abort_count), 0);

        // timeout: port1 stalls for TO cycles mid-packet, port0 waiting
        mac_log.delete();
        for (int i = 0; i < 10; i++) push_beat(1, 8'(128 + i), 1'b0, 1'b0);
        push_idle(1, 8);
        for (int i = 0; i < 5; i++) push_beat(1, 8'(138 + i), (i == 4), 1'b0);
        push_pkt(0, 4);
        wait_idle(2000);
        check("t4_beats", mac_log.size(), 15);
        bad = 0;
        for (int i = 0; i < 10; i++)
            if (mac_log[i] != {8'(128 + i), 1'b0, 1'b0, 1'b1}) bad++;
        check("t4_head", bad, 0);
        check("t4_abort_beat", 32'(mac_log[10]), 32'({8'h00, 1'b1, 1'b1, 1'b1}));
        check("t4_next_grant", 32'(mac_log[11].gidx), 0);
        check("t4_next_data", 32'(mac_log[11].data), 0);
        check("t4_aborts", 32'(abort_count), 1);

        // reset after beat 20 of 64
        do_reset();
        mac_log.delete();
        push_pkt(0, 64);
        n = 0;
        while (mac_log.size() < 20 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) check("t5_wait", 0, 1);
        #1;
        rst = 1'b1;
        flush_req = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_beats_at_reset", mac_log.size(), 20);
        rst = 1'b0;
        push_pkt(1, 4);
        push_pkt(0, 4);
        wait_idle(1000);
        check("t5_beats_total", mac_log.size(), 28);
        check("t5_first_after", 32'(mac_log[20].gidx), 0);
        check("t5_second_after", 32'(mac_log[24].gidx), 1);
        check("t5_aborts", 32'(abort_count), 0);

        // random traffic, stalls and backpressure against the model
        ready_mode = 2;
        for (int p = 0; p < NP; p++) begin
            for (int k = 0; k < 40; k++) begin
                len = $urandom_range(1, 20);
                for (int i = 0; i < len; i++) begin
                    if (i > 0 && $urandom_range(0, 7) == 0) push_idle(p, $urandom_range(1, 10));
                    push_beat(p, 8'($urandom_range(0, 255)), (i == len - 1),
                              ($urandom_range(0, 7) == 0));
                end
                push_idle(p, $urandom_range(0, 3));
            end
        end
        wait_idle(30000);
        ready_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, failed so far %0d", n_fail);
        $fatal(1);
    end

endmodule
